// File: rtl/rf_write_arbiter.sv
// Two-source writeback arbiter for the register file write port: per-source FIFOs,
// round-robin grant, and a registered RF write stage (at most one write per clock).
module rf_write_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_VALID,
    output logic              A_READY,
    input  logic [ADDR_W-1:0] A_RD,
    input  logic [DATA_W-1:0] A_DATA,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [ADDR_W-1:0] B_RD,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              RF_WREN,
    output logic [ADDR_W-1:0] RF_RD,
    output logic [DATA_W-1:0] RF_DATA,
    output logic              BUSY
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    logic [ENT_W-1:0]  a_mem_q [DEPTH];
    logic [ENT_W-1:0]  b_mem_q [DEPTH];
    logic [PTR_W-1:0]  a_wptr_q, a_wptr_d, a_rptr_q, a_rptr_d;
    logic [PTR_W-1:0]  b_wptr_q, b_wptr_d, b_rptr_q, b_rptr_d;
    logic [CNT_W-1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic              last_q, last_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              a_push_s, b_push_s;
    logic              a_nempty_s, b_nempty_s;
    logic              grant_a_s, grant_b_s;
    logic [ENT_W-1:0]  a_head_s, b_head_s;

    // READY depends only on the count, so a full FIFO refuses a push even while popping.
    assign A_READY    = (a_cnt_q != CNT_W'(DEPTH));
    assign B_READY    = (b_cnt_q != CNT_W'(DEPTH));
    assign a_push_s   = A_VALID && A_READY;
    assign b_push_s   = B_VALID && B_READY;
    assign a_nempty_s = (a_cnt_q != {CNT_W{1'b0}});
    assign b_nempty_s = (b_cnt_q != {CNT_W{1'b0}});
    assign a_head_s   = a_mem_q[a_rptr_q];
    assign b_head_s   = b_mem_q[b_rptr_q];

    // When both are pending, the source not granted last time wins.
    assign grant_a_s  = a_nempty_s && (!b_nempty_s || (last_q == LAST_B));
    assign grant_b_s  = b_nempty_s && (!a_nempty_s || (last_q == LAST_A));

    assign RF_WREN    = wren_q;
    assign RF_RD      = rd_q;
    assign RF_DATA    = data_q;
    assign BUSY       = a_nempty_s || b_nempty_s || wren_q;

    // FIFO pointer and occupancy next-state
    always_comb begin
        a_wptr_d = a_push_s  ? (a_wptr_q + PTR_W'(1)) : a_wptr_q;
        a_rptr_d = grant_a_s ? (a_rptr_q + PTR_W'(1)) : a_rptr_q;
        b_wptr_d = b_push_s  ? (b_wptr_q + PTR_W'(1)) : b_wptr_q;
        b_rptr_d = grant_b_s ? (b_rptr_q + PTR_W'(1)) : b_rptr_q;
        case ({a_push_s, grant_a_s})
            2'b10:   a_cnt_d = a_cnt_q + CNT_W'(1);
            2'b01:   a_cnt_d = a_cnt_q - CNT_W'(1);
            default: a_cnt_d = a_cnt_q;
        endcase
        case ({b_push_s, grant_b_s})
            2'b10:   b_cnt_d = b_cnt_q + CNT_W'(1);
            2'b01:   b_cnt_d = b_cnt_q - CNT_W'(1);
            default: b_cnt_d = b_cnt_q;
        endcase
    end

    // Grant bookkeeping and RF write stage next-state; address/data hold when idle
    always_comb begin
        wren_d = grant_a_s || grant_b_s;
        rd_d   = rd_q;
        data_d = data_q;
        last_d = last_q;
        if (grant_a_s) begin
            {rd_d, data_d} = a_head_s;
            last_d         = LAST_A;
        end else if (grant_b_s) begin
            {rd_d, data_d} = b_head_s;
            last_d         = LAST_B;
        end else begin
            last_d = last_q;
        end
    end

    // Control and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_wptr_q <= {PTR_W{1'b0}};
            a_rptr_q <= {PTR_W{1'b0}};
            b_wptr_q <= {PTR_W{1'b0}};
            b_rptr_q <= {PTR_W{1'b0}};
            a_cnt_q  <= {CNT_W{1'b0}};
            b_cnt_q  <= {CNT_W{1'b0}};
            last_q   <= LAST_B;
            wren_q   <= 1'b0;
            rd_q     <= {ADDR_W{1'b0}};
            data_q   <= {DATA_W{1'b0}};
        end else begin
            a_wptr_q <= a_wptr_d;
            a_rptr_q <= a_rptr_d;
            b_wptr_q <= b_wptr_d;
            b_rptr_q <= b_rptr_d;
            a_cnt_q  <= a_cnt_d;
            b_cnt_q  <= b_cnt_d;
            last_q   <= last_d;
            wren_q   <= wren_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
        end
    end

    // FIFO storage
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_mem_q[i] <= {ENT_W{1'b0}};
                b_mem_q[i] <= {ENT_W{1'b0}};
            end
        end else begin
            if (a_push_s) a_mem_q[a_wptr_q] <= {A_RD, A_DATA};
            if (b_push_s) b_mem_q[b_wptr_q] <= {B_RD, B_DATA};
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboarded bench for rf_write_arbiter: per-source expected queues filled on push
// handshakes, drained as RF writes appear, plus a behavioural RF model.
module tb_rf_write_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        A_VALID, B_VALID;
    logic        A_READY, B_READY;
    logic [3:0]  A_RD, B_RD;
    logic [31:0] A_DATA, B_DATA;
    logic        RF_WREN;
    logic [3:0]  RF_RD;
    logic [31:0] RF_DATA;
    logic        BUSY;

    logic [35:0] a_q [$];
    logic [35:0] b_q [$];
    bit          src_log [$];
    logic [31:0] rf_m [16];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          writes_seen = 0;
    bit          saw_b_full = 1'b0;

    rf_write_arbiter #(.DEPTH(2), .ADDR_W(4), .DATA_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_VALID(A_VALID), .A_READY(A_READY), .A_RD(A_RD), .A_DATA(A_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RD(B_RD), .B_DATA(B_DATA),
        .RF_WREN(RF_WREN), .RF_RD(RF_RD), .RF_DATA(RF_DATA), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Register file model: commits on the edge after RF_WREN is presented
    always @(posedge CLK) begin
        if (RF_WREN === 1'b1) rf_m[RF_RD] <= RF_DATA;
    end

    // Scoreboard: check each RF write against the head of its source queue, record pushes
    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            if (RF_WREN === 1'b1) begin
                writes_seen++;
                n_cmp++;
                if (a_q.size() > 0 && {RF_RD, RF_DATA} === a_q[0]) begin
                    void'(a_q.pop_front());
                    src_log.push_back(1'b0);
                end else if (b_q.size() > 0 && {RF_RD, RF_DATA} === b_q[0]) begin
                    void'(b_q.pop_front());
                    src_log.push_back(1'b1);
                end else begin
                    n_fail++;
                    $display("FAIL sb_write: got rd=%0d data=%h, expected head of A (%0d pending) or B (%0d pending)",
                             RF_RD, RF_DATA, a_q.size(), b_q.size());
                end
            end
            if (A_VALID === 1'b1 && A_READY === 1'b1) a_q.push_back({A_RD, A_DATA});
            if (B_VALID === 1'b1 && B_READY === 1'b1) b_q.push_back({B_RD, B_DATA});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic flush_sb();
        a_q.delete();
        b_q.delete();
        src_log.delete();
        writes_seen = 0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; A_VALID = 1'b0; B_VALID = 1'b0;
        #2;
        flush_sb();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((BUSY !== 1'b0 || a_q.size() != 0 || b_q.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= 40) begin
            n_fail++;
            $display("FAIL %s_idle: BUSY=%b pending A=%0d B=%0d after %0d cycles, required idle",
                     name, BUSY, a_q.size(), b_q.size(), n);
        end
    endtask

    task automatic drive_a(input logic [3:0] rd, input logic [31:0] d);
        logic hs = 1'b0;
        int n = 0;
        A_VALID = 1'b1; A_RD = rd; A_DATA = d;
        while (!hs && n < 50) begin
            hs = A_READY;
            tick();
            n++;
        end
        if (!hs) begin
            n_cmp++; n_fail++;
            $display("FAIL a_push_timeout: A_READY=%b, required 1 within 50 cycles", A_READY);
        end
    endtask

    task automatic drive_b(input logic [3:0] rd, input logic [31:0] d);
        logic hs = 1'b0;
        int n = 0;
        B_VALID = 1'b1; B_RD = rd; B_DATA = d;
        while (!hs && n < 50) begin
            hs = B_READY;
            if (!B_READY) saw_b_full = 1'b1;
            tick();
            n++;
        end
        if (!hs) begin
            n_cmp++; n_fail++;
            $display("FAIL b_push_timeout: B_READY=%b, required 1 within 50 cycles", B_READY);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; A_VALID = 1'b0; B_VALID = 1'b0;
        A_RD = 4'd0; A_DATA = 32'd0; B_RD = 4'd0; B_DATA = 32'd0;
        for (int i = 0; i < 16; i++) rf_m[i] = 32'hFFFF_FFFF;
        tick();
        tick();
        n_cmp++; if (RF_WREN !== 1'b0) begin n_fail++; $display("FAIL rst_wren: got %b, required 0", RF_WREN); end
        n_cmp++; if (RF_RD !== 4'd0) begin n_fail++; $display("FAIL rst_rd: got %0d, required 0", RF_RD); end
        n_cmp++; if (RF_DATA !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %h, required 0", RF_DATA); end
        n_cmp++; if (A_READY !== 1'b1 || B_READY !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got A=%b B=%b, required 1/1", A_READY, B_READY); end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", BUSY); end
        RST_N = 1'b1;
        tick();
        n_cmp++; if (RF_WREN !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got wren=%b busy=%b, required 0/0", RF_WREN, BUSY); end
    endtask

    task automatic test_single_write();
        A_VALID = 1'b1; A_RD = 4'd3; A_DATA = 32'd3;
        tick();
        A_VALID = 1'b0;
        n_cmp++; if (BUSY !== 1'b1 || RF_WREN !== 1'b0) begin n_fail++; $display("FAIL single_edge1: got busy=%b wren=%b, required 1/0", BUSY, RF_WREN); end
        tick();
        n_cmp++;
        if (RF_WREN !== 1'b1 || RF_RD !== 4'd3 || RF_DATA !== 32'd3) begin
            n_fail++; $display("FAIL single_edge2: got wren=%b rd=%0d data=%0d, required 1/3/3", RF_WREN, RF_RD, RF_DATA);
        end
        tick();
        n_cmp++; if (rf_m[3] !== 32'd3) begin n_fail++; $display("FAIL single_rf: got r3=%h, required 3", rf_m[3]); end
        n_cmp++; if (BUSY !== 1'b0 || RF_WREN !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b wren=%b, required 0/0", BUSY, RF_WREN); end
        n_cmp++; if (RF_RD !== 4'd3 || RF_DATA !== 32'd3) begin n_fail++; $display("FAIL single_hold: got rd=%0d data=%0d, required 3/3", RF_RD, RF_DATA); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        A_VALID = 1'b1; A_RD = 4'd1; A_DATA = 32'd1;
        B_VALID = 1'b1; B_RD = 4'd2; B_DATA = 32'd2;
        tick();
        A_VALID = 1'b0; B_VALID = 1'b0;
        tick();
        n_cmp++; if (RF_WREN !== 1'b1 || RF_RD !== 4'd1 || RF_DATA !== 32'd1) begin n_fail++; $display("FAIL simul_first: got wren=%b rd=%0d data=%0d, required 1/1/1", RF_WREN, RF_RD, RF_DATA); end
        tick();
        n_cmp++; if (RF_WREN !== 1'b1 || RF_RD !== 4'd2 || RF_DATA !== 32'd2) begin n_fail++; $display("FAIL simul_second: got wren=%b rd=%0d data=%0d, required 1/2/2", RF_WREN, RF_RD, RF_DATA); end
        tick();
        n_cmp++; if (rf_m[1] !== 32'd1 || rf_m[2] !== 32'd2) begin n_fail++; $display("FAIL simul_rf: got r1=%h r2=%h, required 1/2", rf_m[1], rf_m[2]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        saw_b_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) drive_a(4'(4 + i), 32'hA000_0000 + i);
                A_VALID = 1'b0;
            end
            begin
                for (int j = 0; j < 3; j++) drive_b(4'(8 + j), 32'hB000_0000 + j);
                B_VALID = 1'b0;
            end
        join
        wait_idle("b2b");
        n_cmp++; if (saw_b_full !== 1'b1) begin n_fail++; $display("FAIL b2b_b_full: B_READY low seen=%b, required 1", saw_b_full); end
        n_cmp++; if (src_log.size() != 7) begin n_fail++; $display("FAIL b2b_count: got %0d writes, required 7", src_log.size()); end
        for (int k = 0; k < src_log.size(); k++) begin
            n_cmp++;
            if (src_log[k] !== ((k % 2) == 1)) begin
                n_fail++; $display("FAIL b2b_alternate: write %0d from %s, required %s", k, src_log[k] ? "B" : "A", ((k % 2) == 1) ? "B" : "A");
            end
        end
        for (int r = 4; r <= 10; r++) begin
            logic [31:0] exp_v;
            exp_v = (r < 8) ? (32'hA000_0000 + (r - 4)) : (32'hB000_0000 + (r - 8));
            n_cmp++;
            if (rf_m[r] !== exp_v) begin n_fail++; $display("FAIL b2b_rf: got r%0d=%h, required %h", r, rf_m[r], exp_v); end
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        A_VALID = 1'b1; A_RD = 4'd11; A_DATA = 32'h1111_0000;
        B_VALID = 1'b1; B_RD = 4'd12; B_DATA = 32'h2222_0000;
        tick(); tick(); tick();
        n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b, required 1", BUSY); end
        #1;
        RST_N = 1'b0; A_VALID = 1'b0; B_VALID = 1'b0;
        #1;
        n_cmp++; if (RF_WREN !== 1'b0) begin n_fail++; $display("FAIL midrst_wren: got %b, required 0", RF_WREN); end
        n_cmp++; if (A_READY !== 1'b1 || B_READY !== 1'b1 || BUSY !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got ready A=%b B=%b busy=%b, required 1/1/0", A_READY, B_READY, BUSY); end
        flush_sb();
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_cmp++; if (writes_seen != 0) begin n_fail++; $display("FAIL midrst_no_writes: got %0d writes after release, required 0", writes_seen); end
        n_cmp++; if (A_READY !== 1'b1 || B_READY !== 1'b1 || BUSY !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got ready A=%b B=%b busy=%b, required 1/1/0", A_READY, B_READY, BUSY); end
    endtask

    task automatic test_same_rd();
        do_reset();
        A_VALID = 1'b1; A_RD = 4'd5; A_DATA = 32'd8;
        B_VALID = 1'b1; B_RD = 4'd5; B_DATA = 32'd13;
        tick();
        A_VALID = 1'b0; B_VALID = 1'b0;
        tick();
        tick();
        n_cmp++; if (rf_m[5] !== 32'd8) begin n_fail++; $display("FAIL samerd_first: got r5=%0d, required 8", rf_m[5]); end
        tick();
        n_cmp++; if (rf_m[5] !== 32'd13) begin n_fail++; $display("FAIL samerd_final: got r5=%0d, required 13", rf_m[5]); end
        n_cmp++;
        if (src_log.size() != 2 || src_log[0] !== 1'b0 || src_log[1] !== 1'b1) begin
            n_fail++; $display("FAIL samerd_order: got %0d writes, required A then B", src_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_op();
        test_same_rd();
        wait_idle("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
